seg_display_ctrl: RTL and testbench

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

---
 rtl/seg_display_pkg.sv | 41 ++++
 rtl/seg_scan_timer.sv | 47 ++++
 rtl/seg_display_ctrl.sv | 177 +++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared constants for the 7-segment display controller.
// Register offsets, CTRL field positions and the hex-to-segment table.
package seg_display_pkg;

    localparam logic [7:0] OFF_DP    = 8'd4;
    localparam logic [7:0] OFF_BLANK = 8'd5;
    localparam logic [7:0] OFF_CTRL  = 8'd6;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_BRIGHT_LSB = 1;
    localparam int CTRL_BRIGHT_MSB = 3;

    localparam logic [7:0] CTRL_RESET = 8'h0F;

    // Segment pattern, bit order g..a (a = bit 0), active high.
    function automatic logic [6:0] hex7seg(input logic [3:0] value);
        logic [6:0] pat;
        pat = 7'h00;
        case (value)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            4'hF: pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: refresh prescaler plus PWM phase and digit index.
// Phase steps every tick; index steps when phase wraps 7 -> 0.
module seg_scan_timer #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 12500
) (
    input  logic       clk,
    input  logic       rst,
    output logic       tick,
    output logic [2:0] phase,
    output logic [2:0] index
);
    import seg_display_pkg::*;

    localparam int              PRE_W    = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [2:0]      LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [PRE_W-1:0] pre_cnt;

    assign tick = (pre_cnt == PRE_LAST);

    // Prescaler: 0..REFRESH_DIV-1, wrapping on the tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Phase and digit index advance on ticks only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 3'd0;
            index <= 3'd0;
        end else if (tick) begin
            phase <= phase + 3'd1;
            if (phase == 3'd7) begin
                index <= (index == LAST_IDX) ? 3'd0 : index + 3'd1;
            end
        end
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: bus-mapped multiplexed 7-segment display controller.
// Register file, registered bus read port and registered anode/segment drive.
module seg_display_ctrl #(
    parameter logic [7:0] BASE_ADDR   = 8'hD0,
    parameter int         NUM_DIGITS  = 8,
    parameter int         REFRESH_DIV = 12500
) (
    input  logic                  CLK,
    input  logic                  RESET,
    inout  wire  [7:0]            BUS_DATA,
    input  logic [7:0]            BUS_ADDR,
    input  logic                  BUS_WE,
    output logic [NUM_DIGITS-1:0] anodeSelect,
    output logic [7:0]            segmentSelect
);
    import seg_display_pkg::*;

    localparam int NUM_PAIRS = NUM_DIGITS / 2;
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

    logic [7:0]            digit_reg [NUM_PAIRS];
    logic [NUM_DIGITS-1:0] dp_reg;
    logic [NUM_DIGITS-1:0] blank_reg;
    logic                  en_reg;
    logic [2:0]            bright_reg;

    logic [7:0] offset;
    logic       hit_digit;
    logic       hit_dp;
    logic       hit_blank;
    logic       hit_ctrl;
    logic       mapped;
    logic [7:0] rd_value;
    logic [7:0] rd_data;
    logic       rd_oe;

    // The tick is also exported for other consumers; the display
    // stage works purely from phase and index.
    logic       scan_tick_unused;
    logic [2:0] phase;
    logic [2:0] index;

    logic [7:0]            cur_pair;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic                  cur_dp;
    logic                  lit;
    logic [NUM_DIGITS-1:0] anode_next;
    logic [7:0]            seg_next;

    seg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .REFRESH_DIV(REFRESH_DIV)
    ) u_timer (
        .clk  (CLK),
        .rst  (RESET),
        .tick (scan_tick_unused),
        .phase(phase),
        .index(index)
    );

    assign offset = BUS_ADDR - BASE_ADDR;
    assign mapped = hit_digit | hit_dp | hit_blank | hit_ctrl;

    // Address decode and read-data mux for the current bus address.
    always_comb begin
        hit_digit = 1'b0;
        hit_dp    = 1'b0;
        hit_blank = 1'b0;
        hit_ctrl  = 1'b0;
        rd_value  = 8'h00;
        unique case (1'b1)
            (offset < 8'(NUM_PAIRS)): begin
                hit_digit = 1'b1;
                for (int k = 0; k < NUM_PAIRS; k++) begin
                    if (offset == 8'(k)) begin
                        rd_value = digit_reg[k];
                    end
                end
            end
            (offset == OFF_DP): begin
                hit_dp = 1'b1;
                rd_value[NUM_DIGITS-1:0] = dp_reg;
            end
            (offset == OFF_BLANK): begin
                hit_blank = 1'b1;
                rd_value[NUM_DIGITS-1:0] = blank_reg;
            end
            (offset == OFF_CTRL): begin
                hit_ctrl = 1'b1;
                rd_value[CTRL_EN_BIT] = en_reg;
                rd_value[CTRL_BRIGHT_MSB:CTRL_BRIGHT_LSB] = bright_reg;
            end
            default: ;
        endcase
    end

    // Register file writes; unmapped offsets simply fall through.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < NUM_PAIRS; k++) begin
                digit_reg[k] <= 8'h00;
            end
            dp_reg     <= '0;
            blank_reg  <= '0;
            en_reg     <= CTRL_RESET[CTRL_EN_BIT];
            bright_reg <= CTRL_RESET[CTRL_BRIGHT_MSB:CTRL_BRIGHT_LSB];
        end else if (BUS_WE) begin
            for (int k = 0; k < NUM_PAIRS; k++) begin
                if (hit_digit && offset == 8'(k)) begin
                    digit_reg[k] <= BUS_DATA;
                end
            end
            if (hit_dp) begin
                dp_reg <= BUS_DATA[NUM_DIGITS-1:0];
            end
            if (hit_blank) begin
                blank_reg <= BUS_DATA[NUM_DIGITS-1:0];
            end
            if (hit_ctrl) begin
                en_reg     <= BUS_DATA[CTRL_EN_BIT];
                bright_reg <= BUS_DATA[CTRL_BRIGHT_MSB:CTRL_BRIGHT_LSB];
            end
        end
    end

    // Read port: data and drive enable are registered together.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_oe   <= 1'b0;
            rd_data <= 8'h00;
        end else begin
            rd_oe   <= !BUS_WE && mapped;
            rd_data <= rd_value;
        end
    end

    assign BUS_DATA = rd_oe ? rd_data : 8'hzz;

    // Select the scanned digit and decide whether it is lit this phase.
    always_comb begin
        cur_pair  = 8'h00;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int k = 0; k < NUM_PAIRS; k++) begin
            if (index[2:1] == 2'(k)) begin
                cur_pair = digit_reg[k];
            end
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index == 3'(i)) begin
                cur_blank = blank_reg[i];
                cur_dp    = dp_reg[i];
            end
        end
        cur_nib    = index[0] ? cur_pair[7:4] : cur_pair[3:0];
        lit        = en_reg && !cur_blank && (phase <= bright_reg);
        anode_next = '1;
        seg_next   = 8'hFF;
        if (lit) begin
            anode_next = ~(ONE_HOT0 << index);
            seg_next   = ~{cur_dp, hex7seg(cur_nib)};
        end
    end

    // Registered pin drive; a single index keeps at most one anode low.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            anodeSelect   <= '1;
            segmentSelect <= 8'hFF;
        end else begin
            anodeSelect   <= anode_next;
            segmentSelect <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: table vectors, hand sequences and random traffic
// checked every cycle against an arithmetic model of the display.
module tb_seg_display_ctrl;

    localparam int         ND   = 8;
    localparam int         DIV  = 4;
    localparam logic [7:0] BASE = 8'hD0;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic [7:0]    addr  = 8'h00;
    logic          we    = 1'b0;
    logic          drv   = 1'b0;
    logic [7:0]    wdata = 8'h00;
    tri1  [7:0]    bus_data;
    logic [ND-1:0] anode;
    logic [7:0]    seg;

    assign bus_data = drv ? wdata : 8'hzz;

    seg_display_ctrl #(
        .BASE_ADDR  (BASE),
        .NUM_DIGITS (ND),
        .REFRESH_DIV(DIV)
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .BUS_DATA     (bus_data),
        .BUS_ADDR     (addr),
        .BUS_WE       (we),
        .anodeSelect  (anode),
        .segmentSelect(seg)
    );

    always #5 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_bad  = 0;
    int unsigned ecount = 0;

    logic [7:0] m_dig [ND/2];
    logic [7:0] m_dp;
    logic [7:0] m_blank;
    logic [7:0] m_ctrl;
    logic [6:0] seg7 [16];

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] offs(input logic [7:0] a);
        return a - BASE;
    endfunction

    function automatic bit mapped(input logic [7:0] a);
        int o;
        o = int'(offs(a));
        return (o < ND / 2) || (o >= 4 && o <= 6);
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        int o;
        o = int'(offs(a));
        if (o < ND / 2) return m_dig[o];
        if (o == 4) return m_dp;
        if (o == 5) return m_blank;
        if (o == 6) return m_ctrl;
        return 8'hFF;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        int o;
        o = int'(offs(a));
        if (o < ND / 2) m_dig[o] = d;
        else if (o == 4) m_dp = d;
        else if (o == 5) m_blank = d;
        else if (o == 6) m_ctrl = d & 8'h0F;
    endtask

    task automatic model_reset();
        for (int k = 0; k < ND / 2; k++) m_dig[k] = 8'h00;
        m_dp    = 8'h00;
        m_blank = 8'h00;
        m_ctrl  = 8'h0F;
        ecount  = 0;
    endtask

    // Display state after e edges: tick count e/DIV gives phase and digit.
    task automatic model_out(output logic [ND-1:0] an, output logic [7:0] sg);
        int unsigned t;
        int ph, idx;
        logic [7:0] pair;
        logic [3:0] nib;
        t    = ecount / DIV;
        ph   = int'(t % 8);
        idx  = int'((t / 8) % ND);
        pair = m_dig[idx / 2];
        nib  = (idx % 2 == 1) ? pair[7:4] : pair[3:0];
        an = '1;
        sg = 8'hFF;
        if (m_ctrl[0] && !m_blank[idx] && ph <= int'(m_ctrl[3:1])) begin
            an[idx] = 1'b0;
            sg = ~{m_dp[idx], seg7[nib]};
        end
    endtask

    // One clock: drive at negedge, predict, clock, compare at next negedge.
    task automatic cycle(input logic w, input logic [7:0] a, input logic [7:0] d);
        logic [ND-1:0] e_an;
        logic [7:0] e_sg, e_bus;
        we = w; addr = a; wdata = d; drv = w;
        model_out(e_an, e_sg);
        e_bus = (!w && mapped(a)) ? model_read(a) : 8'hFF;
        if (w && mapped(a)) model_write(a, d);
        ecount++;
        @(posedge clk);
        @(negedge clk);
        chk("anode", 32'(anode), 32'(e_an));
        chk("segment", 32'(seg), 32'(e_sg));
        if (!w) chk("bus", 32'(bus_data), 32'(e_bus));
    endtask

    task automatic do_reset();
        we = 1'b0; drv = 1'b0; addr = 8'h00;
        rst = 1'b1;
        #1;
        chk("rst_anode", 32'(anode), 32'hFF);
        chk("rst_seg", 32'(seg), 32'hFF);
        repeat (2) @(negedge clk);
        chk("rst_anode_hold", 32'(anode), 32'hFF);
        chk("rst_bus", 32'(bus_data), 32'hFF);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int cnt0, cnt1, cnt7;
        logic [7:0] a, d;
        int unsigned r;
        bit prev_rd;

        seg7 = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        tbl = '{
            '{1'b1, 8'hD0, 8'h21, 8'h00},
            '{1'b0, 8'hD0, 8'h00, 8'h21},
            '{1'b1, 8'hD1, 8'h43, 8'h00},
            '{1'b0, 8'hD1, 8'h00, 8'h43},
            '{1'b1, 8'hD4, 8'h01, 8'h00},
            '{1'b0, 8'hD4, 8'h00, 8'h01},
            '{1'b1, 8'hD5, 8'h02, 8'h00},
            '{1'b0, 8'hD5, 8'h00, 8'h02},
            '{1'b1, 8'hD6, 8'hFF, 8'h00},
            '{1'b0, 8'hD6, 8'h00, 8'h0F},
            '{1'b1, 8'hD7, 8'hAA, 8'h00},
            '{1'b0, 8'hD7, 8'h00, 8'hFF},
            '{1'b0, 8'hC0, 8'h00, 8'hFF},
            '{1'b0, 8'hD0, 8'h00, 8'h21},
            '{1'b0, 8'hD1, 8'h00, 8'h43},
            '{1'b0, 8'hD5, 8'h00, 8'h02},
            '{1'b1, 8'hD6, 8'h07, 8'h00},
            '{1'b0, 8'hD6, 8'h00, 8'h07}
        };

        @(negedge clk);
        do_reset();

        // Idle scan: 32 cycles per digit, digit 0 first, all showing "0".
        cnt0 = 0; cnt7 = 0;
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, 8'h00, 8'h00);
            if (anode == 8'hFE) cnt0++;
            if (anode == 8'h7F) cnt7++;
        end
        chk("scan_d0_cycles", 32'(cnt0), 32'd32);
        chk("scan_d7_cycles", 32'(cnt7), 32'd32);

        // Write landing on a tick edge shows up one cycle later.
        repeat (3) cycle(1'b0, 8'h00, 8'h00);
        cycle(1'b1, 8'hD0, 8'hFF);
        chk("tick_wr_old", 32'(seg), 32'hC0);
        cycle(1'b0, 8'h00, 8'h00);
        chk("tick_wr_new", 32'(seg), 32'h8E);

        // Register map vectors.
        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].w, tbl[i].a, tbl[i].d);
            if (!tbl[i].w) begin
                chk("tbl_read", 32'(bus_data), 32'(tbl[i].exp_rd));
                cycle(1'b0, 8'h00, 8'h00);
            end
        end

        // BRIGHT=3 with digit 1 blanked, over one full scan.
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, 8'h00, 8'h00);
            if (anode == 8'hFE) cnt0++;
            if (anode == 8'hFD) cnt1++;
        end
        chk("bright3_d0", 32'(cnt0), 32'd16);
        chk("blank_d1", 32'(cnt1), 32'd0);

        // EN=0 blanks everything while scanning carries on.
        cycle(1'b1, 8'hD6, 8'h00);
        repeat (2) cycle(1'b0, 8'h00, 8'h00);
        chk("en_off_anode", 32'(anode), 32'hFF);
        repeat (64) cycle(1'b0, 8'h00, 8'h00);

        // Asynchronous reset while digit 5 is lit and a read is driving.
        @(negedge clk);
        do_reset();
        repeat (170) cycle(1'b0, 8'h00, 8'h00);
        chk("digit5_active", 32'(anode), 32'hDF);
        cycle(1'b0, 8'hD6, 8'h00);
        #2 rst = 1'b1;
        #1;
        chk("async_anode", 32'(anode), 32'hFF);
        chk("async_seg", 32'(seg), 32'hFF);
        chk("async_bus", 32'(bus_data), 32'hFF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1'b0, 8'hD6, 8'h00);
        chk("ctrl_after_rst", 32'(bus_data), 32'h0F);
        chk("restart_d0", 32'(anode), 32'hFE);
        cycle(1'b0, 8'h00, 8'h00);

        // Random bus traffic; a write never directly follows a mapped read.
        prev_rd = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) a = 8'($urandom);
            else a = BASE + 8'($urandom_range(0, 7));
            if (r < 3 && !prev_rd) begin
                cycle(1'b1, a, d);
                prev_rd = 1'b0;
            end else if (r < 6) begin
                cycle(1'b0, a, 8'h00);
                prev_rd = mapped(a);
            end else begin
                cycle(1'b0, 8'h00, 8'h00);
                prev_rd = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
